sd_card_cmd_responder: RTL and testbench

Card-side endpoint of the SD CMD line, used as the bench counterpart and card model for the host CMD path. It deserialises 48-bit command tokens from the host, checks the framing and CRC7, and reports the decoded index and argument. After the N_CR gap it serialises a 48-bit R1-style response (start, transmission=0, echoed index, 32-bit status, CRC7, end) back onto the line with an output enable. One clock domain, CLK_SD_card.

---
 rtl/sd_cmd_pkg.sv | 19 +
 rtl/sd_crc7.sv | 30 +++
 rtl/sd_card_cmd_responder.sv | 150 +++++++++++++++
 tb/tb_sd_card_cmd_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared constants and state encoding for the card-side SD CMD line endpoint.
package sd_cmd_pkg;
    localparam int CMD_FRAME_LEN = 48;
    localparam int CRC_SPAN      = 40;
    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam logic START_BIT = 1'b0;
    localparam logic END_BIT   = 1'b1;
    localparam logic HOST_TX   = 1'b1;
    localparam logic CARD_TX   = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK,
        ST_WAIT_NCR,
        ST_TX
    } state_e;
endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB first, zero initial value; clear wins over enable.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [6:0] crc_o
);
    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = din_i ^ crc_q[6];
        crc_d = crc_q;
        if (clr_i)
            crc_d = '0;
        else if (en_i)
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD endpoint: receives 48-bit host commands, checks framing and
// CRC7, and answers with an R1-style token after an N_CR gap.
module sd_card_cmd_responder
    import sd_cmd_pkg::*;
#(
    parameter int N_CR = 2
) (
    input  logic        CLK_SD_card,
    input  logic        reset,
    input  logic        cmd_from_host,
    input  logic        resp_enable,
    input  logic [31:0] card_status,
    output logic        cmd_to_host,
    output logic        cmd_to_host_oe,
    output logic        cmd_received,
    output logic [5:0]  received_index,
    output logic [31:0] received_arg,
    output logic        crc_error,
    output logic        frame_error,
    output logic        busy
);
    localparam logic [6:0] RX_FIRST = 7'(CMD_FRAME_LEN - 2);
    localparam logic [6:0] TX_FIRST = 7'(CMD_FRAME_LEN - 1);
    localparam logic [6:0] CRC_LAST = 7'(CMD_FRAME_LEN - CRC_SPAN);
    localparam logic [6:0] NCR_INIT = 7'(N_CR);

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [46:0] rx_sr_q, rx_sr_d;
    logic [39:0] tx_sr_q, tx_sr_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic        crc_clr, crc_en, crc_din;
    logic [6:0]  crc;
    logic        tx_bit, frame_bad, crc_bad;

    // One CRC engine serves both directions; RX and TX never overlap.
    sd_crc7 u_crc (
        .clk   (CLK_SD_card),
        .rst   (reset),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .din_i (crc_din),
        .crc_o (crc)
    );

    assign frame_bad = (rx_sr_q[46] != HOST_TX) || (rx_sr_q[0] != END_BIT);
    assign crc_bad   = (rx_sr_q[7:1] != crc);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_sr_d      = rx_sr_q;
        tx_sr_d      = tx_sr_q;
        idx_d        = idx_q;
        arg_d        = arg_q;
        crc_clr      = 1'b0;
        crc_en       = 1'b0;
        crc_din      = cmd_from_host;
        cmd_received = 1'b0;
        crc_error    = 1'b0;
        frame_error  = 1'b0;
        tx_bit       = 1'b1;
        cmd_to_host_oe = 1'b0;
        case (state_q)
            ST_IDLE: begin
                crc_clr = 1'b1;
                if (cmd_from_host == START_BIT) begin
                    state_d = ST_RX;
                    cnt_d   = RX_FIRST;
                end
            end
            ST_RX: begin
                rx_sr_d = {rx_sr_q[45:0], cmd_from_host};
                crc_en  = (cnt_q >= CRC_LAST);
                if (cnt_q == 7'd0) state_d = ST_CHECK;
                else               cnt_d   = cnt_q - 7'd1;
            end
            ST_CHECK: begin
                crc_clr = 1'b1;
                state_d = ST_IDLE;
                if (frame_bad) begin
                    frame_error = 1'b1;
                end else if (crc_bad) begin
                    crc_error = 1'b1;
                end else begin
                    cmd_received = 1'b1;
                    idx_d   = rx_sr_q[45:40];
                    arg_d   = rx_sr_q[39:8];
                    tx_sr_d = {START_BIT, CARD_TX, rx_sr_q[45:40], card_status};
                    if (resp_enable) begin
                        state_d = ST_WAIT_NCR;
                        cnt_d   = NCR_INIT;
                    end
                end
            end
            ST_WAIT_NCR: begin
                crc_clr = 1'b1;
                cnt_d   = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    state_d = ST_TX;
                    cnt_d   = TX_FIRST;
                end
            end
            ST_TX: begin
                cmd_to_host_oe = 1'b1;
                cnt_d = cnt_q - 7'd1;
                if (cnt_q >= CRC_LAST) begin
                    tx_bit  = tx_sr_q[39];
                    tx_sr_d = {tx_sr_q[38:0], 1'b0};
                    crc_en  = 1'b1;
                    crc_din = tx_sr_q[39];
                end else if (cnt_q != 7'd0) begin
                    // Feeding the MSB back cancels the feedback, so the CRC simply shifts out.
                    tx_bit  = crc[6];
                    crc_en  = 1'b1;
                    crc_din = crc[6];
                end else begin
                    tx_bit  = END_BIT;
                    cnt_d   = 7'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_SD_card or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rx_sr_q <= '0;
            tx_sr_q <= '0;
            idx_q   <= '0;
            arg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_sr_q <= rx_sr_d;
            tx_sr_q <= tx_sr_d;
            idx_q   <= idx_d;
            arg_q   <= arg_d;
        end
    end

    assign cmd_to_host    = tx_bit;
    assign received_index = idx_q;
    assign received_arg   = arg_q;
    assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Directed bench for the card-side CMD responder: framing, CRC, response timing, reset abort.
module tb_sd_card_cmd_responder;
    localparam int NCR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_in;
    logic        resp_en;
    logic [31:0] status;
    logic        cmd_to_host, cmd_to_host_oe, cmd_received, crc_error, frame_error, busy;
    logic [5:0]  received_index;
    logic [31:0] received_arg;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sd_card_cmd_responder #(.N_CR(NCR)) dut (
        .CLK_SD_card    (clk),
        .reset          (rst),
        .cmd_from_host  (cmd_in),
        .resp_enable    (resp_en),
        .card_status    (status),
        .cmd_to_host    (cmd_to_host),
        .cmd_to_host_oe (cmd_to_host_oe),
        .cmd_received   (cmd_received),
        .received_index (received_index),
        .received_arg   (received_arg),
        .crc_error      (crc_error),
        .frame_error    (frame_error),
        .busy           (busy)
    );

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:3], c[2] ^ fb, c[1:0], fb};
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, crc7({2'b01, idx, arg}), 1'b1};
    endfunction

    function automatic logic [47:0] mk_resp(input logic [5:0] idx, input logic [31:0] st);
        return {2'b00, idx, st, crc7({2'b00, idx, st}), 1'b1};
    endfunction

    // Called at a negedge; returns at the negedge where the DUT sits in CHECK.
    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            cmd_in = f[i];
            @(negedge clk);
        end
        cmd_in = 1'b1;
    endtask

    // Called at the CHECK negedge; returns at the negedge showing the response end bit.
    task automatic capture_response(input bit inject, output logic [47:0] bits,
                                    output logic oe_all, output logic quiet);
        quiet  = 1'b1;
        oe_all = 1'b1;
        bits   = '0;
        for (int w = 0; w < NCR; w++) begin
            @(negedge clk);
            if (cmd_to_host_oe !== 1'b0 || cmd_to_host !== 1'b1) quiet = 1'b0;
            if (inject) cmd_in = (w == 0) ? 1'b0 : 1'b1;
        end
        for (int b = 47; b >= 0; b--) begin
            @(negedge clk);
            bits[b] = cmd_to_host;
            if (cmd_to_host_oe !== 1'b1) oe_all = 1'b0;
        end
        cmd_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_in = 1'b1; resp_en = 1'b0; status = '0;
        #1;
        n_cmp++;
        if ({cmd_to_host, cmd_to_host_oe, busy} !== 3'b100) begin
            n_bad++; $display("FAIL reset_line: got line/oe/busy=%b want 100", {cmd_to_host, cmd_to_host_oe, busy});
        end
        n_cmp++;
        if ({cmd_received, crc_error, frame_error} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pulses: got %b want 000", {cmd_received, crc_error, frame_error});
        end
        n_cmp++;
        if (received_index !== 6'd0 || received_arg !== 32'd0) begin
            n_bad++; $display("FAIL reset_regs: got idx=%0d arg=%h want 0/0", received_index, received_arg);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cmd0();
        resp_en = 1'b0;
        send_frame(48'h40_0000_0000_95);
        n_cmp++;
        if ({cmd_received, crc_error, frame_error, busy} !== 4'b1001) begin
            n_bad++; $display("FAIL cmd0_check: got rcv/crc/frm/busy=%b want 1001", {cmd_received, crc_error, frame_error, busy});
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, cmd_to_host_oe, cmd_received} !== 3'b000) begin
            n_bad++; $display("FAIL cmd0_after: got busy/oe/rcv=%b want 000", {busy, cmd_to_host_oe, cmd_received});
        end
        n_cmp++;
        if (received_index !== 6'd0 || received_arg !== 32'd0) begin
            n_bad++; $display("FAIL cmd0_decode: got idx=%0d arg=%h want 0/0", received_index, received_arg);
        end
    endtask

    task automatic test_cmd8();
        logic [47:0] bits;
        logic        oe_all, quiet;
        resp_en = 1'b1;
        status  = 32'h0000_01AA;
        send_frame(48'h48_0000_01AA_87);
        n_cmp++;
        if ({cmd_received, crc_error, frame_error} !== 3'b100) begin
            n_bad++; $display("FAIL cmd8_check: got rcv/crc/frm=%b want 100", {cmd_received, crc_error, frame_error});
        end
        capture_response(1'b0, bits, oe_all, quiet);
        n_cmp++;
        if (bits !== mk_resp(6'd8, 32'h0000_01AA)) begin
            n_bad++; $display("FAIL cmd8_resp: got %h want %h", bits, mk_resp(6'd8, 32'h0000_01AA));
        end
        n_cmp++;
        if ({oe_all, quiet} !== 2'b11) begin
            n_bad++; $display("FAIL cmd8_oe: got oe_all/quiet_wait=%b want 11", {oe_all, quiet});
        end
        @(negedge clk);
        n_cmp++;
        if ({cmd_to_host_oe, cmd_to_host, busy} !== 3'b010) begin
            n_bad++; $display("FAIL cmd8_end: got oe/line/busy=%b want 010", {cmd_to_host_oe, cmd_to_host, busy});
        end
        n_cmp++;
        if (received_index !== 6'd8 || received_arg !== 32'h0000_01AA) begin
            n_bad++; $display("FAIL cmd8_decode: got idx=%0d arg=%h want 8/000001aa", received_index, received_arg);
        end
    endtask

    task automatic test_crc_error();
        logic saw_oe;
        resp_en = 1'b1;
        send_frame(mk_cmd(6'd17, 32'h0) ^ 48'h2);
        n_cmp++;
        if ({cmd_received, crc_error, frame_error} !== 3'b010) begin
            n_bad++; $display("FAIL crc_check: got rcv/crc/frm=%b want 010", {cmd_received, crc_error, frame_error});
        end
        saw_oe = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cmd_to_host_oe !== 1'b0) saw_oe = 1'b1;
        end
        n_cmp++;
        if (saw_oe !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL crc_no_resp: got saw_oe=%b busy=%b want 0/0", saw_oe, busy);
        end
        n_cmp++;
        if (received_index !== 6'd8) begin
            n_bad++; $display("FAIL crc_idx_held: got %0d want 8", received_index);
        end
    endtask

    task automatic test_frame_error();
        logic [47:0] f;
        resp_en = 1'b1;
        // End bit low and one CRC bit flipped: the framing fault must win.
        send_frame(mk_cmd(6'd17, 32'h0) ^ 48'h3);
        n_cmp++;
        if ({cmd_received, crc_error, frame_error} !== 3'b001) begin
            n_bad++; $display("FAIL frame_end: got rcv/crc/frm=%b want 001", {cmd_received, crc_error, frame_error});
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || received_index !== 6'd8) begin
            n_bad++; $display("FAIL frame_end_after: got busy=%b idx=%0d want 0/8", busy, received_index);
        end
        f = {2'b00, 6'd17, 32'h0, crc7({2'b00, 6'd17, 32'h0}), 1'b1};
        send_frame(f);
        n_cmp++;
        if ({cmd_received, crc_error, frame_error} !== 3'b001) begin
            n_bad++; $display("FAIL frame_tx_bit: got rcv/crc/frm=%b want 001", {cmd_received, crc_error, frame_error});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_tx();
        resp_en = 1'b1;
        status  = 32'hCAFE_F00D;
        send_frame(mk_cmd(6'd55, 32'h1234_5678));
        repeat (NCR) @(negedge clk);
        repeat (28) @(negedge clk);
        n_cmp++;
        if (cmd_to_host_oe !== 1'b1) begin
            n_bad++; $display("FAIL rst_tx_pre: got oe=%b want 1", cmd_to_host_oe);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({cmd_to_host_oe, cmd_to_host, busy} !== 3'b010) begin
            n_bad++; $display("FAIL rst_tx_abort: got oe/line/busy=%b want 010", {cmd_to_host_oe, cmd_to_host, busy});
        end
        n_cmp++;
        if (received_index !== 6'd0 || received_arg !== 32'd0) begin
            n_bad++; $display("FAIL rst_tx_regs: got idx=%0d arg=%h want 0/0", received_index, received_arg);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        resp_en = 1'b0;
        send_frame(48'h40_0000_0000_95);
        n_cmp++;
        if ({cmd_received, crc_error, frame_error} !== 3'b100) begin
            n_bad++; $display("FAIL rst_cmd0: got rcv/crc/frm=%b want 100", {cmd_received, crc_error, frame_error});
        end
        @(negedge clk);
        n_cmp++;
        if (received_index !== 6'd0 || cmd_to_host_oe !== 1'b0) begin
            n_bad++; $display("FAIL rst_cmd0_after: got idx=%0d oe=%b want 0/0", received_index, cmd_to_host_oe);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] bits;
        logic        oe_all, quiet;
        resp_en = 1'b1;
        status  = 32'hDEAD_BEEF;
        send_frame(mk_cmd(6'd13, 32'h0001_0000));
        capture_response(1'b1, bits, oe_all, quiet);
        n_cmp++;
        if (bits !== mk_resp(6'd13, 32'hDEAD_BEEF) || {oe_all, quiet} !== 2'b11) begin
            n_bad++; $display("FAIL b2b_resp1: got %h oe/quiet=%b want %h 11", bits, {oe_all, quiet}, mk_resp(6'd13, 32'hDEAD_BEEF));
        end
        @(negedge clk);
        n_cmp++;
        if ({cmd_to_host_oe, busy} !== 2'b00) begin
            n_bad++; $display("FAIL b2b_idle: got oe/busy=%b want 00", {cmd_to_host_oe, busy});
        end
        status = 32'h0000_0900;
        send_frame(mk_cmd(6'd55, 32'hA5A5_0000));
        n_cmp++;
        if ({cmd_received, crc_error, frame_error} !== 3'b100) begin
            n_bad++; $display("FAIL b2b_accept: got rcv/crc/frm=%b want 100", {cmd_received, crc_error, frame_error});
        end
        capture_response(1'b0, bits, oe_all, quiet);
        n_cmp++;
        if (bits !== mk_resp(6'd55, 32'h0000_0900) || {oe_all, quiet} !== 2'b11) begin
            n_bad++; $display("FAIL b2b_resp2: got %h oe/quiet=%b want %h 11", bits, {oe_all, quiet}, mk_resp(6'd55, 32'h0000_0900));
        end
        @(negedge clk);
        n_cmp++;
        if (received_index !== 6'd55 || received_arg !== 32'hA5A5_0000 || busy !== 1'b0) begin
            n_bad++; $display("FAIL b2b_decode: got idx=%0d arg=%h busy=%b want 55/a5a50000/0", received_index, received_arg, busy);
        end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_crc_error();
        test_frame_error();
        test_reset_mid_tx();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule
